// File: rtl/param_deco_pkg.sv
// Shared types and constants for the one-hot decoder/scanner.
//   deco_state_t : controller state (idle, static decode, scanning walk)
//   MODE_DECODE / MODE_SCAN : encodings of the i_mode load input
package param_deco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } deco_state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/deco_onehot.sv
// Combinational index-to-one-hot mapper.
//   idx_i    : index to decode
//   active_i : when low the output is all zero
//   onehot_o : DEPTH-wide one-hot (or zero) vector
module deco_onehot #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             active_i,
  output logic [DEPTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (active_i && (idx_i == IDX_W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/param_deco_scanner.sv
// Registered one-hot select generator with DECODE (static) and SCAN (walking)
// modes.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_enable           : block enable; low forces idle
//   i_load_valid/o_load_ready, i_load_idx, i_mode : load handshake
//   i_hold             : extra dwell cycles per position while scanning (live)
//   o_deco_out         : registered one-hot select, zero when idle
//   o_idx              : current index register
//   o_wrap             : one-cycle pulse aligned with the output showing bit 0
//                        after a DEPTH-1 -> 0 wrap
//   o_err              : out-of-range load pulse (only with DECO_RANGE_CHK_EN)
// Build option: DECO_RANGE_CHK_EN rejects out-of-range loads and raises o_err;
// without it such loads are clamped to DEPTH-1.
module param_deco_scanner
  import param_deco_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int HOLD_W = 4,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [IDX_W-1:0]  i_load_idx,
  input  logic              i_mode,
  input  logic [HOLD_W-1:0] i_hold,
  output logic [DEPTH-1:0]  o_deco_out,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_wrap
`ifdef DECO_RANGE_CHK_EN
  ,
  output logic              o_err
`endif
);

  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  deco_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [DEPTH-1:0]  deco_q, deco_d;
  logic              fire;
  logic              out_of_range;
`ifdef DECO_RANGE_CHK_EN
  logic              err_q, err_d;
`endif

  assign o_load_ready = i_enable;
  assign fire         = i_load_valid & i_enable;
  // Widened compare so non-power-of-two DEPTH is detected correctly.
  assign out_of_range = {1'b0, i_load_idx} >= DEPTH_X;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
`ifdef DECO_RANGE_CHK_EN
    err_d   = 1'b0;
`endif
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else if (fire) begin
`ifdef DECO_RANGE_CHK_EN
      if (out_of_range) begin
        err_d = 1'b1;
      end else begin
        idx_d   = i_load_idx;
        cnt_d   = '0;
        state_d = (i_mode == MODE_DECODE) ? ST_DECODE : ST_SCAN;
      end
`else
      idx_d   = out_of_range ? LAST_IDX : i_load_idx;
      cnt_d   = '0;
      state_d = (i_mode == MODE_DECODE) ? ST_DECODE : ST_SCAN;
`endif
    end else if (state_q == ST_SCAN) begin
      // >= so that lowering i_hold mid-dwell advances on the next cycle.
      if (cnt_q >= i_hold) begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // One-hot is built from next-state so the registered output lines up with
  // o_idx and o_wrap.
  deco_onehot #(.DEPTH(DEPTH)) u_onehot (
    .idx_i    (idx_d),
    .active_i (state_d != ST_IDLE),
    .onehot_o (deco_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      deco_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      deco_q  <= deco_d;
    end
  end

`ifdef DECO_RANGE_CHK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign o_err = err_q;
`endif

  assign o_deco_out = deco_q;
  assign o_idx      = idx_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_param_deco_scanner.sv
module tb_param_deco_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=8 instance
  logic       en8 = 1'b0, lv8 = 1'b0, md8 = 1'b0, rdy8, wrap8;
  logic [2:0] li8 = '0, idx8;
  logic [3:0] hold8 = '0;
  logic [7:0] deco8;
  // DEPTH=5 instance
  logic       en5 = 1'b0, lv5 = 1'b0, md5 = 1'b0, rdy5, wrap5;
  logic [2:0] li5 = '0, idx5;
  logic [3:0] hold5 = '0;
  logic [4:0] deco5;
`ifdef DECO_RANGE_CHK_EN
  logic err8, err5;
`endif

  param_deco_scanner #(.DEPTH(8), .HOLD_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_enable(en8), .i_load_valid(lv8),
    .o_load_ready(rdy8), .i_load_idx(li8), .i_mode(md8), .i_hold(hold8),
    .o_deco_out(deco8), .o_idx(idx8), .o_wrap(wrap8)
`ifdef DECO_RANGE_CHK_EN
    , .o_err(err8)
`endif
  );

  param_deco_scanner #(.DEPTH(5), .HOLD_W(4)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_enable(en5), .i_load_valid(lv5),
    .o_load_ready(rdy5), .i_load_idx(li5), .i_mode(md5), .i_hold(hold5),
    .o_deco_out(deco5), .o_idx(idx5), .o_wrap(wrap5)
`ifdef DECO_RANGE_CHK_EN
    , .o_err(err5)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: active flag, scanning flag, index, dwell count.
  typedef struct {
    bit active;
    bit scanning;
    int idx;
    int cnt;
    bit wrap;
    bit err;
  } model_t;

  model_t m8, m5;

  function automatic model_t mstep(model_t m, int depth, bit en, bit lv,
                                   int li, bit md, int hold);
    model_t n;
    n = m;
    n.wrap = 0;
    n.err  = 0;
    if (!en) begin
      n.active = 0;
      n.scanning = 0;
    end else if (lv) begin
      if (li >= depth) begin
`ifdef DECO_RANGE_CHK_EN
        n.err = 1;
        return n;
`else
        li = depth - 1;
`endif
      end
      n.idx = li;
      n.cnt = 0;
      n.active = 1;
      n.scanning = md;
    end else if (m.active && m.scanning) begin
      if (m.cnt >= hold) begin
        n.cnt  = 0;
        n.idx  = (m.idx + 1) % depth;
        n.wrap = (n.idx == 0);
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    return n;
  endfunction

  function automatic model_t mreset();
    model_t r;
    r = '{active: 0, scanning: 0, idx: 0, cnt: 0, wrap: 0, err: 0};
    return r;
  endfunction

  function automatic logic [31:0] exp_deco(model_t m);
    return m.active ? (32'd1 << m.idx) : 32'd0;
  endfunction

  // Advance one clock, step both models with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    m8 = mstep(m8, 8, en8, lv8, int'(li8), md8, int'(hold8));
    m5 = mstep(m5, 5, en5, lv5, int'(li5), md5, int'(hold5));
    #1;
  endtask

  task automatic check_models();
    chk("m8_deco", 32'(deco8), exp_deco(m8));
    chk("m8_idx",  32'(idx8),  32'(m8.idx));
    chk("m8_wrap", 32'(wrap8), 32'(m8.wrap));
    chk("m5_deco", 32'(deco5), exp_deco(m5));
    chk("m5_idx",  32'(idx5),  32'(m5.idx));
    chk("m5_wrap", 32'(wrap5), 32'(m5.wrap));
`ifdef DECO_RANGE_CHK_EN
    chk("m8_err",  32'(err8),  32'(m8.err));
    chk("m5_err",  32'(err5),  32'(m5.err));
`endif
  endtask

  typedef struct {
    bit         en;
    bit         lv;
    logic [2:0] li;
    bit         md;
    logic [3:0] hold;
    logic [7:0] deco;
    logic [2:0] idx;
    bit         wrap;
  } vec_t;

  vec_t tbl[17];

  initial begin
    m8 = mreset();
    m5 = mreset();

    // Reset state
    #2;
    chk("rst_deco8", 32'(deco8), 0);
    chk("rst_idx8",  32'(idx8),  0);
    chk("rst_wrap8", 32'(wrap8), 0);
    chk("rst_deco5", 32'(deco5), 0);
    chk("rst_rdy8",  32'(rdy8),  0);
    #1 rst = 1'b0;
    en8 = 1'b1;
    en5 = 1'b1;
    tick();
    check_models();

    // DEPTH=8 directed table, one row per clock
    tbl[0]  = '{1, 1, 3'd5, 0, 4'd0, 8'h20, 3'd5, 0};
    tbl[1]  = '{1, 1, 3'd0, 0, 4'd0, 8'h01, 3'd0, 0};
    tbl[2]  = '{1, 1, 3'd6, 1, 4'd2, 8'h40, 3'd6, 0};
    tbl[3]  = '{1, 0, 3'd0, 0, 4'd2, 8'h40, 3'd6, 0};
    tbl[4]  = '{1, 0, 3'd0, 0, 4'd2, 8'h40, 3'd6, 0};
    tbl[5]  = '{1, 0, 3'd0, 0, 4'd2, 8'h80, 3'd7, 0};
    tbl[6]  = '{1, 0, 3'd0, 0, 4'd2, 8'h80, 3'd7, 0};
    tbl[7]  = '{1, 0, 3'd0, 0, 4'd2, 8'h80, 3'd7, 0};
    tbl[8]  = '{1, 0, 3'd0, 0, 4'd2, 8'h01, 3'd0, 1};
    tbl[9]  = '{1, 0, 3'd0, 0, 4'd2, 8'h01, 3'd0, 0};
    tbl[10] = '{1, 0, 3'd0, 0, 4'd0, 8'h02, 3'd1, 0};
    tbl[11] = '{0, 1, 3'd3, 0, 4'd0, 8'h00, 3'd1, 0};
    tbl[12] = '{1, 0, 3'd0, 0, 4'd0, 8'h00, 3'd1, 0};
    tbl[13] = '{1, 1, 3'd7, 1, 4'd1, 8'h80, 3'd7, 0};
    tbl[14] = '{1, 0, 3'd0, 0, 4'd1, 8'h80, 3'd7, 0};
    tbl[15] = '{1, 1, 3'd2, 0, 4'd1, 8'h04, 3'd2, 0};
    tbl[16] = '{1, 0, 3'd0, 0, 4'd1, 8'h04, 3'd2, 0};

    for (int i = 0; i < 17; i++) begin
      en8 = tbl[i].en;
      lv8 = tbl[i].lv;
      li8 = tbl[i].li;
      md8 = tbl[i].md;
      hold8 = tbl[i].hold;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 32'(rdy8), 32'(tbl[i].en));
      tick();
      chk($sformatf("tbl%0d_deco", i), 32'(deco8), 32'(tbl[i].deco));
      chk($sformatf("tbl%0d_idx", i),  32'(idx8),  32'(tbl[i].idx));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap8), 32'(tbl[i].wrap));
      check_models();
    end
    lv8 = 1'b0;

    // DECODE holds for 20 cycles
    en8 = 1'b1; lv8 = 1'b1; li8 = 3'd5; md8 = 1'b0;
    tick();
    lv8 = 1'b0;
    chk("dec5_first", 32'(deco8), 32'h20);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dec5_hold", 32'(deco8), 32'h20);
    end
    check_models();

    // DEPTH=5 scan with hold 0 from idx 3: 3,4,0(wrap),1
    en5 = 1'b1; lv5 = 1'b1; li5 = 3'd3; md5 = 1'b1; hold5 = 4'd0;
    tick();
    lv5 = 1'b0;
    chk("d5_s0", 32'(idx5), 3);
    chk("d5_s0_deco", 32'(deco5), 32'h08);
    tick();
    chk("d5_s1", 32'(idx5), 4);
    chk("d5_s1_wrap", 32'(wrap5), 0);
    tick();
    chk("d5_s2", 32'(idx5), 0);
    chk("d5_s2_wrap", 32'(wrap5), 1);
    chk("d5_s2_deco", 32'(deco5), 32'h01);
    tick();
    chk("d5_s3", 32'(idx5), 1);
    chk("d5_s3_wrap", 32'(wrap5), 0);
    // Out-of-range load
    lv5 = 1'b1; li5 = 3'd6; md5 = 1'b0;
    tick();
    lv5 = 1'b0;
`ifdef DECO_RANGE_CHK_EN
    chk("d5_oor_err", 32'(err5), 1);
    chk("d5_oor_idx", 32'(idx5), 1);
    chk("d5_oor_deco", 32'(deco5), 32'h02);
    tick();
    chk("d5_oor_err_off", 32'(err5), 0);
`else
    chk("d5_clamp_idx", 32'(idx5), 4);
    chk("d5_clamp_deco", 32'(deco5), 32'h10);
    tick();
    chk("d5_clamp_hold", 32'(idx5), 4);
`endif
    check_models();

    // Asynchronous reset mid-scan
    en8 = 1'b1; lv8 = 1'b1; li8 = 3'd3; md8 = 1'b1; hold8 = 4'd0;
    tick();
    lv8 = 1'b0;
    tick();
    tick();
    chk("pre_rst_idx", 32'(idx8), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_deco", 32'(deco8), 0);
    chk("arst_idx",  32'(idx8),  0);
    chk("arst_wrap", 32'(wrap8), 0);
    chk("arst_deco5", 32'(deco5), 0);
    m8 = mreset();
    m5 = mreset();
    #1 rst = 1'b0;
    tick();
    check_models();

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      en8 = ($urandom_range(0, 9) != 0);
      lv8 = ($urandom_range(0, 5) == 0);
      li8 = 3'($urandom_range(0, 7));
      md8 = 1'($urandom_range(0, 1));
      hold8 = 4'($urandom_range(0, 3));
      en5 = ($urandom_range(0, 9) != 0);
      lv5 = ($urandom_range(0, 5) == 0);
      li5 = 3'($urandom_range(0, 7));
      md5 = 1'($urandom_range(0, 1));
      hold5 = 4'($urandom_range(0, 2));
      #1;
      chk("rnd_rdy8", 32'(rdy8), 32'(en8));
      chk("rnd_rdy5", 32'(rdy5), 32'(en5));
      tick();
      check_models();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
